// File: rtl/inst_line_fetcher.sv
// Instruction-line fill engine: reads one aligned line from a synchronous-read RAM, one word per cycle.
// Latency: first word two cycles after accept; stalls re-drive the held word address so ram_douta stays put.
module inst_line_fetcher #(
  parameter int LINE_WORDS_LOG = 3,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic [31:0]               req_addr,
  output logic                      req_ready,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_addra,
  output logic [3:0]                ram_wea,
  output logic [DATA_W-1:0]         ram_dina,
  input  logic [DATA_W-1:0]         ram_douta,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [LINE_WORDS_LOG-1:0] rsp_idx,
  output logic                      rsp_last
);

  localparam int LINE_W = ADDR_W - LINE_WORDS_LOG;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                    state_q, state_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [LINE_WORDS_LOG:0]   issue_idx_q, issue_idx_d;
  logic                      pend_q, pend_d;
  logic [LINE_WORDS_LOG-1:0] rsp_idx_q, rsp_idx_d;

  logic stall;
  logic words_left;
  logic last_fire;
  logic unused_req_bits;

  // Base is kept as a line number; word address is {line, idx}, so there is never a carry.
  assign stall           = pend_q & ~rsp_ready;
  assign words_left      = ~issue_idx_q[LINE_WORDS_LOG];
  assign last_fire       = pend_q & rsp_ready & (&rsp_idx_q);
  assign unused_req_bits = ^{req_addr[31:ADDR_W+2], req_addr[LINE_WORDS_LOG+1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = FETCH;
      FETCH:   if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d      = line_q;
    issue_idx_d = issue_idx_q;
    pend_d      = pend_q;
    rsp_idx_d   = rsp_idx_q;
    if (state_q == IDLE) begin
      issue_idx_d = '0;
      pend_d      = 1'b0;
      rsp_idx_d   = '0;
      if (req_valid) line_d = req_addr[ADDR_W+1:LINE_WORDS_LOG+2];
    end else if (!stall) begin
      if (words_left) begin
        issue_idx_d = issue_idx_q + 1'b1;
        pend_d      = 1'b1;
        rsp_idx_d   = issue_idx_q[LINE_WORDS_LOG-1:0];
      end else if (pend_q && rsp_ready) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q      <= '0;
      issue_idx_q <= '0;
      pend_q      <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      line_q      <= line_d;
      issue_idx_q <= issue_idx_d;
      pend_q      <= pend_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    ram_addra = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      FETCH: begin
        busy      = 1'b1;
        rsp_valid = pend_q;
        // Under stall the word on ram_douta is re-read so its data stays stable.
        if (!stall && words_left) ram_addra = {line_q, issue_idx_q[LINE_WORDS_LOG-1:0]};
        else                      ram_addra = {line_q, rsp_idx_q};
      end
      default: ;
    endcase
  end

  assign rsp_idx  = rsp_idx_q;
  assign rsp_last = rsp_valid & (&rsp_idx_q);
  assign rsp_data = ram_douta;
  assign ram_wea  = '0;
  assign ram_dina = '0;

  hold_under_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_idx)));

endmodule

// File: tb/tb_inst_line_fetcher.sv
// Bench for inst_line_fetcher: directed line fills plus randomized requests/backpressure
// checked against a transaction-level timing model of the fill.
module tb_inst_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        busy;
  logic [11:0] ram_addra;
  logic [3:0]  ram_wea;
  logic [31:0] ram_dina;
  logic [31:0] ram_douta;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_idx;
  logic        rsp_last;

  inst_line_fetcher #(.LINE_WORDS_LOG(3), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready), .busy(busy),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_idx(rsp_idx), .rsp_last(rsp_last)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  initial for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 + i;
  always @(posedge clk) begin
    if (ram_wea != 4'h0) mem[ram_addra] <= ram_dina;
    ram_douta <= mem[ram_addra];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: an accepted line shows nothing on the cycle after accept, then words 0..7 in
  // order, each staying until taken; the cycle after the last word is taken is IDLE.
  int          cyc = 0;
  bit          m_fetch = 0;
  int          m_t;
  int          m_k;
  logic [11:0] m_base;
  int          acc_cyc, last_cyc, last_lat;

  task automatic step(input logic v, input logic [31:0] a, input logic r);
    logic [11:0] wa;
    @(posedge clk); #1;
    req_valid = v; req_addr = a; rsp_ready = r;
    @(negedge clk);
    check_eq("wea_zero", 32'(ram_wea), 32'h0);
    check_eq("dina_zero", ram_dina, 32'h0);
    if (!m_fetch) begin
      check_eq("idle_req_ready", 32'(req_ready), 32'h1);
      check_eq("idle_busy", 32'(busy), 32'h0);
      check_eq("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      check_eq("idle_rsp_last", 32'(rsp_last), 32'h0);
      check_eq("idle_addra", 32'(ram_addra), 32'h0);
      if (v) begin
        m_fetch = 1; m_t = 1; m_k = 0; acc_cyc = cyc;
        m_base = {a[13:5], 3'b000};
      end
    end else begin
      check_eq("fetch_req_ready", 32'(req_ready), 32'h0);
      check_eq("fetch_busy", 32'(busy), 32'h1);
      if (m_t == 1) begin
        check_eq("first_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("first_addra", 32'(ram_addra), 32'(m_base));
        m_t = 2;
      end else begin
        wa = m_base + 12'(m_k);
        check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("rsp_idx", 32'(rsp_idx), 32'(m_k));
        check_eq("rsp_data", rsp_data, 32'hA500_0000 + 32'(wa));
        check_eq("rsp_last", 32'(rsp_last), 32'(m_k == 7));
        if (!r)          check_eq("stall_addra", 32'(ram_addra), 32'(wa));
        else if (m_k < 7) check_eq("next_addra", 32'(ram_addra), 32'(wa + 12'd1));
        if (r) begin
          if (m_k == 7) begin
            m_fetch = 0; last_cyc = cyc; last_lat = cyc - acc_cyc;
          end
          m_k++;
        end
      end
    end
    cyc++;
  endtask

  task automatic drain(input bit rand_ready, input bit rand_valid);
    int guard = 0;
    while (m_fetch && guard < 200) begin
      step(rand_valid ? 1'($urandom) : 1'b0, $urandom, rand_ready ? ($urandom_range(3) != 0) : 1'b1);
      guard++;
    end
    if (m_fetch) begin
      check_eq("fill_timeout", 32'h1, 32'h0);
      m_fetch = 0;
    end
  endtask

  int first_last;
  int rel;
  int bad_words;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    #12;
    check_eq("rst_req_ready", 32'(req_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_last", 32'(rsp_last), 32'h0);
    check_eq("rst_rsp_idx", 32'(rsp_idx), 32'h0);
    check_eq("rst_addra", 32'(ram_addra), 32'h0);
    check_eq("rst_wea", 32'(ram_wea), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Line at 0x48 with no backpressure: last word 9 cycles after accept.
    step(1'b1, 32'h0000_0048, 1'b1);
    drain(0, 0);
    check_eq("lat_nostall", 32'(last_lat), 32'd9);
    step(1'b0, 32'h0, 1'b1);

    // Same line, rsp_ready low on cycles 4..6 after accept.
    step(1'b1, 32'h0000_0048, 1'b1);
    begin
      int guard = 0;
      while (m_fetch && guard < 50) begin
        rel = cyc - acc_cyc;
        step(1'b0, 32'h0, !(rel >= 4 && rel <= 6));
        guard++;
      end
    end
    check_eq("lat_stall3", 32'(last_lat), 32'd12);

    // Top line of the RAM: no wrap.
    step(1'b1, 32'h0000_3FFC, 1'b1);
    drain(0, 0);
    check_eq("lat_topline", 32'(last_lat), 32'd9);

    // req_valid held across two back-to-back lines.
    step(1'b1, 32'h0000_0000, 1'b1);
    begin
      int guard = 0;
      while (m_fetch && guard < 50) begin
        step(1'b1, 32'h0000_0020, 1'b1);
        guard++;
      end
    end
    first_last = last_cyc;
    step(1'b1, 32'h0000_0020, 1'b1);
    check_eq("b2b_accept_cycle", 32'(acc_cyc), 32'(first_last + 1));
    drain(0, 0);

    // Reset while idx 3 is on the response port.
    step(1'b1, 32'h0000_0100, 1'b1);
    begin
      int guard = 0;
      while (!(m_fetch && m_t == 2 && m_k == 3) && guard < 20) begin
        step(1'b0, 32'h0, 1'b1);
        guard++;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    check_eq("pre_rst_idx", 32'(rsp_idx), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_addra", 32'(ram_addra), 32'h0);
    check_eq("arst_rsp_last", 32'(rsp_last), 32'h0);
    check_eq("arst_req_ready", 32'(req_ready), 32'h1);
    m_fetch = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc += 2;
    step(1'b1, 32'h0000_0480, 1'b1);
    drain(0, 0);
    check_eq("post_rst_lat", 32'(last_lat), 32'd9);

    // Randomized requests, gaps, backpressure and stray req_valid during fills.
    for (int n = 0; n < 250; n++) begin
      for (int g = 0; g < int'($urandom_range(2)); g++) step(1'b0, $urandom, 1'($urandom));
      step(1'b1, $urandom, 1'($urandom));
      drain(1, 1);
    end
    step(1'b0, 32'h0, 1'b1);

    bad_words = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== 32'hA500_0000 + i) bad_words++;
    check_eq("ram_intact", 32'(bad_words), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
